// File: rtl/mosby_pkg.sv
// Shared definitions for the mosby fetch/decode front end.
package mosby_pkg;

  localparam int          FETCH_ADDR_W   = 16;
  localparam int          FETCH_DEPTH    = 4;
  localparam logic [15:0] FETCH_RESET_PC = 16'h0200;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [7:0] OP_BRK     = 8'h00;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  function automatic logic [15:0] sat_add16(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Byte-wide circular prefetch FIFO; clear wins over push/pop.
// Head reads as 8'h00 while the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  input  logic                   clear,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = (count == '0) ? 8'h00 : mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, memory req/ack, prefetch queue.
// Optional FETCH_PERF_EN adds saturating fetched/discarded counters.
module fetch_unit
  import mosby_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_rdata,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_addr,
  input  logic                   consume,
  output logic [7:0]             instruction,
  output logic                   normal,
  output logic [ADDR_W-1:0]      head_pc,
  output logic [$clog2(DEPTH):0] queue_count
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]            perf_fetched,
  output logic [15:0]            perf_discarded
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  fetch_state_e      state_nx;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] hold_addr;
  logic              in_req;
  logic              in_disc;
  logic              push;
  logic              pop;
  logic [CW:0]       level;
  logic              level_ok;

  assign in_req   = (state == REQ);
  assign in_disc  = (state == DISCARD);
  assign normal   = (queue_count != '0);
  assign pop      = consume && normal && !flush;
  assign push     = in_req && mem_ack && !flush;
  assign mem_req  = in_req || in_disc;
  assign mem_addr = in_disc ? hold_addr : fetch_pc;

  // Occupancy after this cycle's ack and pop; decides back-to-back.
  assign level    = {1'b0, queue_count} + (CW+1)'(1)
                  - {{CW{1'b0}}, pop};
  assign level_ok = level < (CW+1)'(DEPTH);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!flush && (queue_count < CW'(DEPTH)))
          state_nx = REQ;
      end
      REQ: begin
        if (flush)
          state_nx = mem_ack ? REQ : DISCARD;
        else if (mem_ack && !level_ok)
          state_nx = IDLE;
      end
      DISCARD: begin
        if (mem_ack) state_nx = REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
      head_pc   <= RESET_PC;
    end else begin
      state <= state_nx;
      if (flush)
        fetch_pc <= flush_addr;
      else if (push)
        fetch_pc <= fetch_pc + ADDR_W'(1);
      // Keep the abandoned address on the bus until memory answers.
      if (in_req && flush && !mem_ack)
        hold_addr <= fetch_pc;
      if (flush)
        head_pc <= flush_addr;
      else if (pop)
        head_pc <= head_pc + ADDR_W'(1);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (mem_rdata),
    .pop   (pop),
    .clear (flush),
    .head  (instruction),
    .count (queue_count)
  );

`ifdef FETCH_PERF_EN
  logic [15:0] drop_n;
  logic        drop_ack;

  assign drop_ack = mem_ack && (in_disc || (in_req && flush));

  always_comb begin
    drop_n = {15'b0, drop_ack};
    if (flush) drop_n = drop_n + 16'(queue_count);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      perf_fetched   <= sat_add16(perf_fetched, {15'b0, push});
      perf_discarded <= sat_add16(perf_discarded, drop_n);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Drives and samples on the falling clock edge.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        flush;
  logic [15:0] flush_addr;
  logic        consume;
  logic [7:0]  instruction;
  logic        normal;
  logic [15:0] head_pc;
  logic [2:0]  queue_count;

  logic        w_rst;
  logic        w_req;
  logic [15:0] w_addr;
  logic        w_ack;
  logic [7:0]  w_rdata;
  logic        w_flush;
  logic [15:0] w_flush_addr;
  logic        w_consume;
  logic [7:0]  w_instr;
  logic        w_normal;
  logic [15:0] w_head_pc;
  logic [2:0]  w_count;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_discarded;
  logic [15:0] w_perf_fetched;
  logic [15:0] w_perf_discarded;
`endif

  int          n_tests;
  int          n_fail;
  int          lat;
  int          lat_cnt;
  bit          auto_mem;
  logic [15:0] log_q[$];
  logic [15:0] w_log[$];

  fetch_unit u_dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .consume     (consume),
    .instruction (instruction),
    .normal      (normal),
    .head_pc     (head_pc),
    .queue_count (queue_count)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded)
`endif
  );

  fetch_unit #(
    .RESET_PC (16'hFFFE)
  ) u_wrap (
    .clk         (clk),
    .rst         (w_rst),
    .mem_req     (w_req),
    .mem_addr    (w_addr),
    .mem_ack     (w_ack),
    .mem_rdata   (w_rdata),
    .flush       (w_flush),
    .flush_addr  (w_flush_addr),
    .consume     (w_consume),
    .instruction (w_instr),
    .normal      (w_normal),
    .head_pc     (w_head_pc),
    .queue_count (w_count)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (w_perf_fetched),
    .perf_discarded (w_perf_discarded)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rom(input logic [15:0] a);
    case (a)
      16'h0200: return 8'h69;
      16'h0201: return 8'h05;
      16'h0202: return 8'hEA;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  task automatic cyc();
    @(negedge clk);
    mem_ack = 1'b0;
    flush   = 1'b0;
    consume = 1'b0;
    w_ack   = 1'b0;
    if (auto_mem && mem_req) begin
      if (lat_cnt == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rom(mem_addr);
        log_q.push_back(mem_addr);
        lat_cnt   = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    auto_mem   = 1'b0;
    lat_cnt    = 0;
    log_q.delete();
    flush_addr = '0;
    mem_rdata  = '0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 30 && mem_req; i++) cyc();
    check(tag, mem_req, 1'b0);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    w_rst        = 1'b0;
    w_rdata      = '0;
    w_flush      = 1'b0;
    w_flush_addr = '0;
    w_consume    = 1'b0;
    w_ack        = 1'b0;
    mem_ack      = 1'b0;
    flush        = 1'b0;
    consume      = 1'b0;
    lat          = 1;

    // Reset values
    rst        = 1'b0;
    auto_mem   = 1'b0;
    lat_cnt    = 0;
    flush_addr = '0;
    mem_rdata  = '0;
    cyc();
    cyc();
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 16'h0200);
    check("rst_normal", normal, 1'b0);
    check("rst_instr", instruction, 8'h00);
    check("rst_count", queue_count, 3'd0);
    check("rst_head_pc", head_pc, 16'h0200);
    rst = 1'b1;

    // Fetch with one wait state per request, no consume
    auto_mem = 1'b1;
    lat      = 1;
    cyc();
    check("s1_first_req", mem_req, 1'b1);
    check("s1_first_addr", mem_addr, 16'h0200);
    cyc();
    cyc();
    check("s1_normal", normal, 1'b1);
    check("s1_instr", instruction, 8'h69);
    check("s1_head_pc", head_pc, 16'h0200);
    wait_idle("s1_full_idle");
    for (int i = 0; i < 5; i++) cyc();
    check("s1_n_fetch", log_q.size(), 4);
    check("s1_addr1", log_q[1], 16'h0201);
    check("s1_addr2", log_q[2], 16'h0202);
    check("s1_full_count", queue_count, 3'd4);
    check("s1_still_idle", mem_req, 1'b0);

    // One consume frees one slot
    consume = 1'b1;
    cyc();
    check("s2_pop_count", queue_count, 3'd3);
    check("s2_pop_instr", instruction, 8'h05);
    check("s2_pop_head_pc", head_pc, 16'h0201);
    cyc();
    check("s2_refetch_addr", mem_addr, 16'h0204);
    wait_idle("s2_refill_idle");
    for (int i = 0; i < 5; i++) cyc();
    check("s2_n_fetch", log_q.size(), 5);
    check("s2_last_addr", log_q[4], 16'h0204);
    check("s2_count", queue_count, 3'd4);

    // Flush while a request is pending, ack two cycles later
    do_reset();
    cyc();
    check("s3_req", mem_req, 1'b1);
    flush      = 1'b1;
    flush_addr = 16'h1234;
    cyc();
    check("s3_disc_req", mem_req, 1'b1);
    check("s3_disc_addr", mem_addr, 16'h0200);
    check("s3_disc_head", head_pc, 16'h1234);
    consume = 1'b1;
    cyc();
    check("s3_empty_pop", queue_count, 3'd0);
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    cyc();
    check("s3_drop_count", queue_count, 3'd0);
    check("s3_drop_normal", normal, 1'b0);
    check("s3_new_addr", mem_addr, 16'h1234);
    check("s3_new_req", mem_req, 1'b1);
    check("s3_head_pc", head_pc, 16'h1234);
    mem_ack   = 1'b1;
    mem_rdata = 8'h42;
    cyc();
    check("s3_refetch_instr", instruction, 8'h42);
    check("s3_refetch_count", queue_count, 3'd1);
`ifdef FETCH_PERF_EN
    check("s3_perf_fetched", perf_fetched, 16'd1);
    check("s3_perf_discarded", perf_discarded, 16'd1);
`endif

    // Consume and ack in the same cycle
    do_reset();
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 8'h11;
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 8'h22;
    consume   = 1'b1;
    cyc();
    check("s4a_count", queue_count, 3'd1);
    check("s4a_instr", instruction, 8'h22);
    check("s4a_head_pc", head_pc, 16'h0201);
    check("s4a_addr", mem_addr, 16'h0202);

    // Flush, consume and ack together with two bytes queued
    do_reset();
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 8'h11;
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 8'h22;
    cyc();
    check("s4_pre_count", queue_count, 3'd2);
    mem_ack    = 1'b1;
    mem_rdata  = 8'h33;
    consume    = 1'b1;
    flush      = 1'b1;
    flush_addr = 16'h0ABC;
    cyc();
    check("s4_count", queue_count, 3'd0);
    check("s4_normal", normal, 1'b0);
    check("s4_instr", instruction, 8'h00);
    check("s4_req", mem_req, 1'b1);
    check("s4_addr", mem_addr, 16'h0ABC);
    check("s4_head_pc", head_pc, 16'h0ABC);
    mem_ack   = 1'b1;
    mem_rdata = 8'h44;
    cyc();
    check("s4_next_instr", instruction, 8'h44);
    check("s4_next_count", queue_count, 3'd1);
`ifdef FETCH_PERF_EN
    check("s4_perf_fetched", perf_fetched, 16'd3);
    check("s4_perf_discarded", perf_discarded, 16'd3);
`endif

    // Address wrap and reset mid-request on the FFFE instance
    cyc();
    w_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (w_req) begin
        w_log.push_back(w_addr);
        w_ack   = 1'b1;
        w_rdata = 8'(i + 1);
      end
    end
    cyc();
    check("s5_n_fetch", w_log.size(), 3);
    check("s5_addr0", w_log[0], 16'hFFFE);
    check("s5_addr1", w_log[1], 16'hFFFF);
    check("s5_addr2", w_log[2], 16'h0000);
    check("s5_count", w_count, 3'd3);
    check("s5_pending", w_req, 1'b1);
    #2;
    w_rst = 1'b0;
    #1;
    check("s5_rst_req", w_req, 1'b0);
    check("s5_rst_addr", w_addr, 16'hFFFE);
    check("s5_rst_count", w_count, 3'd0);
    cyc();
    w_rst   = 1'b1;
    w_ack   = 1'b1;
    w_rdata = 8'hCC;
    cyc();
    check("s5_late_count", w_count, 3'd0);
    check("s5_late_normal", w_normal, 1'b0);
    check("s5_late_addr", w_addr, 16'hFFFE);
    check("s5_late_req", w_req, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Generates program-counter addresses and runs a req/ack handshake with external memory.
- Buffers fetched bytes in a small prefetch queue and presents the head byte to the decoder as instruction/normal.
- Discards queued and in-flight bytes on flush and refetches from the branch target.

Parameters:
- ADDR_W, 16, program-counter / memory address width.
- DEPTH, 4, prefetch queue entries (power of two, ≥2).
- RESET_PC, 16'h0200, fetch address loaded at reset.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request to memory.
- mem_addr  out  ADDR_W  fetch address; stable while mem_req=1.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid this cycle.
- mem_rdata  in  8  fetched byte.
- flush  in  1  branch taken: discard everything, refetch at flush_addr.
- flush_addr  in  ADDR_W  branch target.
- consume  in  1  decoder pops head byte.
- instruction  out  8  head byte of queue.
- normal  out  1  head byte valid (queue non-empty).
- head_pc  out  ADDR_W  address of head byte.
- queue_count  out  $clog2(DEPTH)+1  bytes held.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC, head_pc=RESET_PC.
  - queue empty, queue_count=0, normal=0, instruction=8'h00.
  - mem_req=0, mem_addr=RESET_PC, state=IDLE.
  - Reset mid-handshake abandons the request; a late mem_ack is ignored.
- FSM states: IDLE, REQ, DISCARD.
  - IDLE: if (queue_count + 0) < DEPTH and no flush, assert mem_req with mem_addr=fetch_pc and go to REQ. The first mem_req occurs the first clk edge after rst deasserts.
  - REQ: mem_req stays 1 and mem_addr stays stable until mem_ack.
    - On ack: write mem_rdata to the queue tail and increment fetch_pc (wraps 16'hFFFF→16'h0000).
    - If space remains after the write (counting a simultaneous consume), stay in REQ with mem_req=1 and the new address (back-to-back). Otherwise go to IDLE with mem_req=0.
  - DISCARD: entered when flush occurs in REQ without a same-cycle ack. mem_req and mem_addr are held (the handshake is never dropped mid-flight). On ack the data is dropped and the state goes to REQ at fetch_pc (already set to flush_addr).
- Queue:
  - Circular buffer with read/write pointers.
  - Byte written on the ack edge → normal=1 the next cycle (ack-to-normal latency 1 cycle).
- consume:
  - consume with normal=1 pops the head: head_pc increments, and the next byte appears the following cycle.
  - consume with normal=0 is ignored.
  - consume and ack in the same cycle: count is unchanged and both pointers advance.
- flush (highest priority):
  - Same cycle effects: queue cleared, normal=0 next cycle, fetch_pc=head_pc=flush_addr.
  - Overrides a same-cycle consume and a same-cycle ack; the acked byte is dropped.
  - flush in REQ with ack in the same cycle goes straight to REQ at flush_addr, not DISCARD.
  - flush in DISCARD restarts with the newest flush_addr.
- Full: no request issues while queue_count + outstanding = DEPTH. The queue never overflows.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (16-bit, count of bytes enqueued) and perf_discarded (16-bit, bytes dropped by flush, both queued and in-flight). Both are saturating, reset to 0, and clear on rst only.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mosby_pkg:
  - fetch FSM state enum (IDLE/REQ/DISCARD).
  - ADDR_W and RESET_PC constants.
  - opcode constants shared with the decoder (e.g. ADC immediate 8'h69).
- Sub-module fetch_queue: parameterised DEPTH×8 circular FIFO with push, pop, clear, count, and head outputs. fetch_unit holds the FSM and PC logic.

Test Plan:
- Reset release, memory acks 1 cycle after each req returning 69,05,EA → mem_addr 0200,0201,0202 in turn. normal=1 with instruction=69 three cycles after first req. head_pc=0200.
- No consume, always-ack memory → exactly 4 bytes fetched, then mem_req=0 and queue_count=4. One consume → exactly one new request at 0204.
- flush with flush_addr=1234 while REQ is pending and ack arrives 2 cycles later → that byte is dropped, queue_count=0, next mem_addr=1234, head_pc=1234.
- flush, consume and mem_ack in the same cycle with 2 bytes queued → queue empty next cycle, acked byte discarded, next mem_addr=flush_addr.
- RESET_PC=FFFE, fetch 3 bytes → addresses FFFE, FFFF, 0000 (wrap). Assert rst mid-REQ → mem_req=0 immediately and a late ack is ignored.
- FETCH_PERF_EN defined, scenario 3 run → perf_fetched=1 and perf_discarded=1.
